// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Instruction-level controller for the single-bus R1/R2/R3 + ALU datapath.
//   Instructions arrive over a valid/ready handshake into a small FIFO and
//   are executed one at a time as timed sequences of register/bus enables
//   and ALU operation selects.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   instr_valid/rdy  instruction handshake; instr = {opcode[3:0], dst[1:0], imm}
//   ext_valid        external operand present on the ExternBuf source
//   ext_ack          external operand consumed this cycle
//   imm_value        value driven onto the ImmBuf source
//   enable_signals   {R3en, R2en, R1en, OutBuf, ImmBuf, ExternBuf}
//   alu_op           ALU operation select (holds outside ALU states)
//   done             pulse on the final cycle of a legal instruction
//   err              pulse while an illegal instruction is retired
//   busy             sequencer active or FIFO holds instructions
module datapath_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  ALU_ADD    = 4'd0,
  parameter logic [3:0]  ALU_OR     = 4'd1,
  parameter logic [3:0]  ALU_NOT    = 4'd2,
  parameter logic [3:0]  ALU_XOR    = 4'd3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5+DATA_W:0] instr,
  input  logic              ext_valid,
  output logic              ext_ack,
  output logic [DATA_W-1:0] imm_value,
  output logic [5:0]        enable_signals,
  output logic [3:0]        alu_op,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IW = DATA_W + 6;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDX = 4'd1;
  localparam logic [3:0] OP_LDI = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd8;

  typedef enum logic [2:0] {
    IDLE, EXEC, ALU_SETUP, ALU_WRITE, WAIT_EXT, ERR
  } state_t;

  // ---------------------------------------------------------------------------
  // Instruction FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic [IW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [IW-1:0] head;
  logic [3:0]    head_op;
  logic [1:0]    head_dst;
  logic [DATA_W-1:0] head_imm;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign instr_ready = !full;
  assign push        = instr_valid && !full;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign head_op     = head[IW-1:IW-4];
  assign head_dst    = head[DATA_W+1:DATA_W];
  assign head_imm    = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_legal(input logic [3:0] op, input logic [1:0] dst);
    logic needs_dst;
    needs_dst = (op == OP_LDX) || (op == OP_LDI) || (op == OP_MOV);
    if (op > OP_OUT) return 1'b0;
    if (needs_dst && (dst == 2'b00 || dst == 2'b11)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State, instruction register and held output registers.
  // The IR keeps opcode/dst only; the immediate is captured straight into the
  // imm_value holding register at fetch of a legal LDI, so it equals IR.imm
  // during execution and holds afterwards.
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [3:0]        ir_op;
  logic [1:0]        ir_dst;
  logic [3:0]        alu_q;
  logic [DATA_W-1:0] imm_q;
  logic              head_legal, head_is_alu, fetch;

  assign head_legal  = is_legal(head_op, head_dst);
  assign head_is_alu = head_op inside {OP_ADD, OP_OR, OP_NOT, OP_XOR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_op   <= '0;
      ir_dst  <= '0;
      alu_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        ir_op  <= head_op;
        ir_dst <= head_dst;
        if (head_legal && head_is_alu)        alu_q <= alu_code(head_op);
        if (head_legal && head_op == OP_LDI)  imm_q <= head_imm;
      end
    end
  end

  assign alu_op    = alu_q;
  assign imm_value = imm_q;
  assign busy      = (state_q != IDLE) || !empty;

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  logic [5:0] rd_en;
  assign rd_en = {1'b0, ir_dst == 2'b10, ir_dst == 2'b01, 3'b000};

  always_comb begin
    state_d        = state_q;
    fetch          = 1'b0;
    pop            = 1'b0;
    enable_signals = '0;
    done           = 1'b0;
    err            = 1'b0;
    ext_ack        = 1'b0;

    case (state_q)
      IDLE: fetch = 1'b1;
      EXEC: begin
        fetch = 1'b1;
        done  = 1'b1;
        case (ir_op)
          OP_LDX: begin
            enable_signals = rd_en | 6'b000001;
            ext_ack        = 1'b1;
          end
          OP_LDI:  enable_signals = rd_en | 6'b000010;
          OP_MOV:  enable_signals = rd_en | 6'b000100;
          OP_OUT:  enable_signals = 6'b000100;
          default: enable_signals = '0;
        endcase
      end
      ALU_SETUP: state_d = ALU_WRITE;
      ALU_WRITE: begin
        fetch          = 1'b1;
        done           = 1'b1;
        enable_signals = 6'b100000;
      end
      WAIT_EXT: if (ext_valid) state_d = EXEC;
      ERR: begin
        fetch = 1'b1;
        err   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fetch) begin
      if (empty) begin
        state_d = IDLE;
      end else begin
        pop = 1'b1;
        if (!head_legal)                          state_d = ERR;
        else if (head_is_alu)                     state_d = ALU_SETUP;
        else if (head_op == OP_LDX && !ext_valid) state_d = WAIT_EXT;
        else                                      state_d = EXEC;
      end
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: a per-cycle vector table for
// the basic instruction flow plus hand-written multi-cycle sequences for
// FIFO back-pressure, illegal instructions and mid-instruction reset.
module tb_datapath_sequencer;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LDX = 4'd1, OP_LDI = 4'd2, OP_ADD = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4, OP_NOT = 4'd5, OP_XOR = 4'd6, OP_MOV = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [13:0] instr = '0;
  logic        ext_valid = 1'b0;
  logic        instr_ready, ext_ack, done, err, busy;
  logic [7:0]  imm_value;
  logic [5:0]  enable_signals;
  logic [3:0]  alu_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(
    .DATA_W(8), .FIFO_DEPTH(4),
    .ALU_ADD(4'd0), .ALU_OR(4'd1), .ALU_NOT(4'd2), .ALU_XOR(4'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ext_valid(ext_valid), .ext_ack(ext_ack), .imm_value(imm_value),
    .enable_signals(enable_signals), .alu_op(alu_op),
    .done(done), .err(err), .busy(busy)
  );

  function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] dst,
                                     input logic [7:0] imm);
    return {op, dst, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [13:0] in;
    logic        ev;
    logic [5:0]  en;
    logic        dn, er, ak;
    logic [3:0]  alu;
    logic [7:0]  imm;
    logic        bsy;
  } vec_t;

  vec_t tbl [22];

  task automatic setv(input int i, input logic v, input logic [13:0] in, input logic ev,
                      input logic [5:0] en, input logic dn, input logic ak,
                      input logic [3:0] alu, input logic [7:0] imm, input logic bsy);
    tbl[i].v = v;  tbl[i].in = in; tbl[i].ev = ev;  tbl[i].en = en;
    tbl[i].dn = dn; tbl[i].er = 1'b0; tbl[i].ak = ak;
    tbl[i].alu = alu; tbl[i].imm = imm; tbl[i].bsy = bsy;
  endtask

  // Expected done-cycle outputs for the stalled-LDX / full-FIFO sequence
  logic [5:0]  seqa_en  [6] = '{6'b010001, 6'b001010, 6'b010010, 6'b001100, 6'b000100, 6'b001010};
  logic [7:0]  seqa_imm [6] = '{8'h5A, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33};
  logic [5:0]  got_en   [8];
  logic [7:0]  got_imm  [8];
  logic [13:0] q [5];
  logic [13:0] bad_seq [3];

  initial begin
    int k, acks, errs, dones, bad;
    logic pend, found;
    logic [5:0] last_en;

    //            v   instr                       ev  en         dn ak alu    imm    bsy
    setv( 0, 1'b1, mk(OP_LDI, 2'b01, 8'h5A), 1'b0, 6'b000000, 0, 0, 4'd0, 8'h00, 0);
    setv( 1, 1'b1, mk(OP_OR,  2'b00, 8'h00), 1'b0, 6'b000000, 0, 0, 4'd0, 8'h00, 1);
    setv( 2, 1'b0, 14'h0,                    1'b0, 6'b001010, 1, 0, 4'd0, 8'h5A, 1);
    setv( 3, 1'b0, 14'h0,                    1'b0, 6'b000000, 0, 0, 4'd1, 8'h5A, 1);
    setv( 4, 1'b0, 14'h0,                    1'b0, 6'b100000, 1, 0, 4'd1, 8'h5A, 1);
    setv( 5, 1'b1, mk(OP_MOV, 2'b10, 8'h00), 1'b0, 6'b000000, 0, 0, 4'd1, 8'h5A, 0);
    setv( 6, 1'b1, mk(OP_OUT, 2'b00, 8'h00), 1'b0, 6'b000000, 0, 0, 4'd1, 8'h5A, 1);
    setv( 7, 1'b1, mk(OP_NOP, 2'b00, 8'h00), 1'b0, 6'b010100, 1, 0, 4'd1, 8'h5A, 1);
    setv( 8, 1'b0, 14'h0,                    1'b0, 6'b000100, 1, 0, 4'd1, 8'h5A, 1);
    setv( 9, 1'b0, 14'h0,                    1'b0, 6'b000000, 1, 0, 4'd1, 8'h5A, 1);
    setv(10, 1'b1, mk(OP_LDX, 2'b01, 8'h00), 1'b1, 6'b000000, 0, 0, 4'd1, 8'h5A, 0);
    setv(11, 1'b0, 14'h0,                    1'b1, 6'b000000, 0, 0, 4'd1, 8'h5A, 1);
    setv(12, 1'b0, 14'h0,                    1'b0, 6'b001001, 1, 1, 4'd1, 8'h5A, 1);
    setv(13, 1'b1, mk(OP_NOT, 2'b00, 8'h00), 1'b0, 6'b000000, 0, 0, 4'd1, 8'h5A, 0);
    setv(14, 1'b0, 14'h0,                    1'b0, 6'b000000, 0, 0, 4'd1, 8'h5A, 1);
    setv(15, 1'b0, 14'h0,                    1'b0, 6'b000000, 0, 0, 4'd2, 8'h5A, 1);
    setv(16, 1'b0, 14'h0,                    1'b0, 6'b100000, 1, 0, 4'd2, 8'h5A, 1);
    setv(17, 1'b1, mk(OP_ADD, 2'b00, 8'h00), 1'b0, 6'b000000, 0, 0, 4'd2, 8'h5A, 0);
    setv(18, 1'b0, 14'h0,                    1'b0, 6'b000000, 0, 0, 4'd2, 8'h5A, 1);
    setv(19, 1'b0, 14'h0,                    1'b0, 6'b000000, 0, 0, 4'd0, 8'h5A, 1);
    setv(20, 1'b0, 14'h0,                    1'b0, 6'b100000, 1, 0, 4'd0, 8'h5A, 1);
    setv(21, 1'b0, 14'h0,                    1'b0, 6'b000000, 0, 0, 4'd0, 8'h5A, 0);

    // ---- reset state ----
    #2;
    chk("rst_en",   32'(enable_signals), 32'h0);
    chk("rst_alu",  32'(alu_op),         32'h0);
    chk("rst_imm",  32'(imm_value),      32'h0);
    chk("rst_done", 32'(done),           32'h0);
    chk("rst_err",  32'(err),            32'h0);
    chk("rst_ack",  32'(ext_ack),        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven per-cycle vectors ----
    for (int i = 0; i < 22; i++) begin
      instr_valid = tbl[i].v;
      instr       = tbl[i].in;
      ext_valid   = tbl[i].ev;
      @(negedge clk);
      chk($sformatf("v%0d_en", i),   32'(enable_signals), 32'(tbl[i].en));
      chk($sformatf("v%0d_done", i), 32'(done),           32'(tbl[i].dn));
      chk($sformatf("v%0d_err", i),  32'(err),            32'(tbl[i].er));
      chk($sformatf("v%0d_ack", i),  32'(ext_ack),        32'(tbl[i].ak));
      chk($sformatf("v%0d_alu", i),  32'(alu_op),         32'(tbl[i].alu));
      chk($sformatf("v%0d_imm", i),  32'(imm_value),      32'(tbl[i].imm));
      chk($sformatf("v%0d_busy", i), 32'(busy),           32'(tbl[i].bsy));
      chk($sformatf("v%0d_rdy", i),  32'(instr_ready),    32'h1);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    ext_valid   = 1'b0;

    // ---- LDX stall with a full FIFO, then in-order drain ----
    q[0] = mk(OP_LDI, 2'b01, 8'h11);
    q[1] = mk(OP_LDI, 2'b10, 8'h22);
    q[2] = mk(OP_MOV, 2'b01, 8'h00);
    q[3] = mk(OP_OUT, 2'b00, 8'h00);
    q[4] = mk(OP_LDI, 2'b01, 8'h33);
    instr = mk(OP_LDX, 2'b10, 8'h00);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      instr = q[i];
      @(negedge clk);
      chk($sformatf("stall%0d_en", i),  32'(enable_signals), 32'h0);
      chk($sformatf("stall%0d_ack", i), 32'(ext_ack),        32'h0);
      chk($sformatf("stall%0d_rdy", i), 32'(instr_ready),    32'h1);
      @(posedge clk); #1;
    end
    instr = q[4];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("full%0d_rdy", i),  32'(instr_ready),    32'h0);
      chk($sformatf("full%0d_en", i),   32'(enable_signals), 32'h0);
      chk($sformatf("full%0d_busy", i), 32'(busy),           32'h1);
      @(posedge clk); #1;
    end
    ext_valid = 1'b1;
    k = 0;
    acks = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      pend = instr_valid && instr_ready;
      if (ext_ack) acks++;
      if (done && k < 8) begin
        got_en[k]  = enable_signals;
        got_imm[k] = imm_value;
        k++;
      end
      @(posedge clk); #1;
      if (pend) instr_valid = 1'b0;
      ext_valid = 1'b0;
    end
    instr_valid = 1'b0;
    chk("seqa_count", 32'(k), 32'd6);
    chk("seqa_acks", 32'(acks), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < k) begin
        chk($sformatf("seqa%0d_en", i),  32'(got_en[i]),  32'(seqa_en[i]));
        chk($sformatf("seqa%0d_imm", i), 32'(got_imm[i]), 32'(seqa_imm[i]));
      end
    end
    chk("seqa_idle_busy", 32'(busy), 32'h0);

    // ---- illegal opcode, illegal dst, then a legal MOV ----
    bad_seq[0] = mk(4'hC, 2'b01, 8'h00);
    bad_seq[1] = mk(OP_LDI, 2'b00, 8'hEE);
    bad_seq[2] = mk(OP_MOV, 2'b01, 8'h00);
    errs = 0; dones = 0; bad = 0; last_en = '0;
    for (int c = 0; c < 10; c++) begin
      instr_valid = (c < 3);
      if (c < 3) instr = bad_seq[c];
      @(negedge clk);
      if (err) errs++;
      if (done) begin
        dones++;
        last_en = enable_signals;
      end else if (enable_signals != 6'b0) begin
        bad++;
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("ill_errs",   32'(errs),      32'd2);
    chk("ill_dones",  32'(dones),     32'd1);
    chk("ill_stray",  32'(bad),       32'd0);
    chk("ill_mov_en", 32'(last_en),   32'b001100);
    chk("ill_imm",    32'(imm_value), 32'h33);

    // ---- reset in ALU_SETUP with three instructions queued ----
    instr_valid = 1'b1;
    instr = mk(OP_LDX, 2'b01, 8'h00);
    @(posedge clk); #1;
    instr = mk(OP_XOR, 2'b00, 8'h00);
    @(posedge clk); #1;
    instr = mk(OP_LDI, 2'b10, 8'h44);
    @(posedge clk); #1;
    instr = mk(OP_MOV, 2'b10, 8'h00);
    @(posedge clk); #1;
    instr = mk(OP_OUT, 2'b00, 8'h00);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ext_valid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (alu_op == 4'd3) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("rstm_reached_setup", 32'(found), 32'h1);
    chk("rstm_setup_en", 32'(enable_signals), 32'h0);
    chk("rstm_setup_full", 32'(instr_ready), 32'h1);
    #1 rst_n = 1'b0;
    ext_valid = 1'b0;
    #1;
    chk("rstm_en",   32'(enable_signals), 32'h0);
    chk("rstm_alu",  32'(alu_op),         32'h0);
    chk("rstm_imm",  32'(imm_value),      32'h0);
    chk("rstm_done", 32'(done),           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("post%0d_busy", c), 32'(busy),           32'h0);
      chk($sformatf("post%0d_en", c),   32'(enable_signals), 32'h0);
      chk($sformatf("post%0d_done", c), 32'(done),           32'h0);
      chk($sformatf("post%0d_rdy", c),  32'(instr_ready),    32'h1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Instruction-level controller for the single-bus R1/R2/R3 + ALU datapath. Accepts encoded instructions over a valid/ready handshake into a small FIFO, decodes each one into a timed sequence of enable_signals (R3en/R2en/R1en/OutBuf/ImmBuf/ExternBuf) and alu_op, and stalls on the external operand handshake. It replaces hand-stepped FSM state selection with queued instruction execution.

Parameters:
DATA_W, 8, width of immediate/data path
FIFO_DEPTH, 4, instruction FIFO entries (power of 2, >=2)
ALU_ADD, 4'd0, alu_op code for ADD
ALU_OR, 4'd1, alu_op code for OR
ALU_NOT, 4'd2, alu_op code for NOT
ALU_XOR, 4'd3, alu_op code for XOR

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  FIFO can accept (= !full)
instr  in  6+DATA_W  [5+DATA_W:2+DATA_W] opcode, [1+DATA_W:DATA_W] dst, [DATA_W-1:0] imm
ext_valid  in  1  external operand present on ExternBuf source
ext_ack  out  1  external operand consumed this cycle
imm_value  out  DATA_W  value driven to ImmBuf source
enable_signals  out  6  {R3en,R2en,R1en,OutBuf,ImmBuf,ExternBuf}
alu_op  out  4  ALU operation select
done  out  1  1-cycle pulse on final cycle of a legal instruction
err  out  1  1-cycle pulse on illegal instruction
busy  out  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE, enable_signals=0, alu_op=0, imm_value=0, done=err=ext_ack=0, instr_ready=1 after release.
- Opcodes: 0 NOP, 1 LDX, 2 LDI, 3 ADD, 4 OR, 5 NOT, 6 XOR, 7 MOV, 8 OUT; 9-15 illegal. dst: 01=R1, 10=R2; 00/11 illegal for LDX/LDI/MOV, ignored otherwise.
- FIFO: push when instr_valid&&instr_ready. No push when full, even if popping the same cycle. Pop only when state machine takes a new instruction into its instruction register (IR).
- States: IDLE, EXEC, ALU_SETUP, ALU_WRITE, WAIT_EXT, ERR.
- Fetch: in IDLE, or on the final cycle of any instruction, if FIFO non-empty, pop into IR and go to: ERR (illegal), ALU_SETUP (ADD/OR/NOT/XOR), WAIT_EXT (LDX with ext_valid=0), EXEC (all others). Otherwise go to IDLE.
- Back-to-back: single-cycle ops sustain 1 instr/cycle.
- Min latency: push at edge N, pop at edge N+1, enables active in cycle N+1..N+2.
- Outputs decode from state+IR only; no combinational path from inputs to outputs, except ext_ack.
- EXEC enables: LDX {Rd,ExternBuf} with ext_ack=1; LDI {Rd,ImmBuf}, imm_value=IR.imm; MOV {Rd,OutBuf}; OUT {OutBuf}; NOP 0. done=1.
- WAIT_EXT: enables 0. When ext_valid=1, go to EXEC. LDX enters EXEC directly when ext_valid is already 1 at fetch.
- ALU_SETUP: alu_op=code, enables 0.
- ALU_WRITE: alu_op held, enables {R3en}, done=1.
- alu_op holds its last value outside ALU states. imm_value holds until the next LDI.
- ERR: enables 0, err=1, then fetch as a final cycle. Illegal instructions never assert any enable.
- At most one of OutBuf/ImmBuf/ExternBuf is ever asserted (bus contention invariant).
- Reset mid-instruction: outputs drop to reset values immediately; FIFO contents are discarded.

Test Plan:
- Reset then push LDI dst=01 imm=8'h5A -> cycle after pop: enable_signals=6'b001010, imm_value=8'h5A, done=1; next cycle enables=0, busy=0.
- Push ADD -> ALU_SETUP: alu_op=ALU_ADD, enables=0; ALU_WRITE: enables=6'b100000, alu_op still ALU_ADD, done=1; total 2 cycles.
- Push LDX dst=10 with ext_valid=0 for 3 cycles, then 1 -> enables=0 during wait; then enables=6'b010001, ext_ack=1 for exactly 1 cycle.
- Push 5 instructions back-to-back with FIFO_DEPTH=4 and sequencer stalled on LDX -> instr_ready=0 after 4 queued; all execute in order after ext_valid.
- Push opcode 4'hC, then LDI dst=00 -> err pulses twice, enables stay 0, done never asserts; the following MOV dst=01 gives 6'b001100.
- Assert rst_n=0 mid ALU_SETUP with 3 queued instructions -> enables=0 and alu_op=0 immediately; after release busy=0, no queued instruction executes.
